// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: bus widths, the NOP opcode and the loader FSM states.
package cpu_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 8;

  localparam logic [CPU_DATA_W-1:0] CPU_NOP = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/prog_ram.sv
// Program array: synchronous write, asynchronous read, no reset on contents.
module prog_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [DATA_W-1:0] rData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
  end

  // Zero-latency read: the CPU decodes in the same cycle it drives the address.
  assign rData = mem[rAddr];

endmodule

// File: rtl/program_memory.sv
// Loadable program store: byte loader fills the array while the CPU is held in reset,
// then serves combinational instruction fetches once a complete load has finished.
module program_memory
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memVal,
  input  logic              loadStart,
  input  logic [ADDR_W-1:0] loadLen,
  input  logic              loadValid,
  input  logic [DATA_W-1:0] loadData,
  output logic              loadReady,
  output logic              loadDone,
  output logic [DATA_W-1:0] loadSum,
  output logic              cpuHold,
  output state_t            dbgState
);

  // Handshake: a byte transfers on every rising edge where loadValid && loadReady;
  // loadReady is high exactly while in LOAD, so the source may stream one byte per cycle.

  state_t            state, nextState;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   lenCount;
  logic              accept;
  logic              lastByte;
  logic              startLoad;
  logic [DATA_W-1:0] ramData;

  // A length of zero means a full-array load.
  assign lenCount  = (loadLen == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, loadLen};
  assign accept    = (state == LOAD) && loadValid;
  assign lastByte  = (remaining == (ADDR_W + 1)'(1));
  assign startLoad = (state != LOAD) && loadStart;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (loadStart) nextState = LOAD;
      LOAD: if (accept && lastByte) nextState = RUN;
      RUN:  if (loadStart) nextState = LOAD;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr     <= '0;
      remaining <= '0;
      loadSum   <= '0;
      loadDone  <= 1'b0;
    end else begin
      loadDone <= accept && lastByte;
      if (startLoad) begin
        wrPtr     <= '0;
        remaining <= lenCount;
        loadSum   <= '0;
      end else if (accept) begin
        wrPtr     <= wrPtr + 1'b1;
        remaining <= remaining - 1'b1;
        loadSum   <= loadSum + loadData;
      end
    end
  end

  prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .wAddr (wrPtr),
    .wData (loadData),
    .rAddr (memAddr),
    .rData (ramData)
  );

  // Outside RUN the CPU only ever sees NOPs, even though it is also held in reset.
  assign memVal    = (state == RUN) ? ramData : DATA_W'(CPU_NOP);
  assign loadReady = (state == LOAD);
  assign cpuHold   = (state != RUN);
  assign dbgState  = state;

endmodule

// File: tb/tb_program_memory.sv
// Scoreboard bench for program_memory: drivers push expectations, a negedge monitor checks them.
module tb_program_memory;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] memAddr;
  logic [7:0] memVal;
  logic       loadStart;
  logic [7:0] loadLen;
  logic       loadValid;
  logic [7:0] loadData;
  logic       loadReady;
  logic       loadDone;
  logic [7:0] loadSum;
  logic       cpuHold;
  state_t     dbgState;

  always #5 clk = ~clk;

  program_memory dut (
    .clk       (clk),
    .rst       (rst),
    .memAddr   (memAddr),
    .memVal    (memVal),
    .loadStart (loadStart),
    .loadLen   (loadLen),
    .loadValid (loadValid),
    .loadData  (loadData),
    .loadReady (loadReady),
    .loadDone  (loadDone),
    .loadSum   (loadSum),
    .cpuHold   (cpuHold),
    .dbgState  (dbgState)
  );

  // Reference model: byte array, written flags, and whether the CPU should be running.
  logic [7:0] refMem [256];
  bit         refWr  [256];
  bit         modelRun;
  logic [7:0] srcBuf [256];

  logic [7:0] exp_rd_q[$];
  logic [2:0] exp_st_q[$];
  logic [7:0] exp_sum_q[$];
  logic [7:0] exp_lsum_q[$];

  int checks = 0;
  int errors = 0;
  bit endReq = 1'b0;
  bit monDone = 1'b0;

  // Monitor
  always @(negedge clk) begin
    logic [7:0] e;
    logic [2:0] s;
    while (exp_st_q.size() > 0) begin
      s = exp_st_q.pop_front();
      checks++;
      if ({cpuHold, loadReady, loadDone} !== s) begin
        errors++;
        $display("FAIL status hold/ready/done got=%b exp=%b t=%0t", {cpuHold, loadReady, loadDone}, s, $time);
      end
    end
    if (loadDone === 1'b1) begin
      checks++;
      if (exp_sum_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done loadDone=1 with no load pending t=%0t", $time);
      end else begin
        e = exp_sum_q.pop_front();
        if (loadSum !== e) begin
          errors++;
          $display("FAIL load_sum got=%h exp=%h t=%0t", loadSum, e, $time);
        end
      end
    end
    while (exp_lsum_q.size() > 0) begin
      e = exp_lsum_q.pop_front();
      checks++;
      if (loadSum !== e) begin
        errors++;
        $display("FAIL sum_state got=%h exp=%h t=%0t", loadSum, e, $time);
      end
    end
    while (exp_rd_q.size() > 0) begin
      e = exp_rd_q.pop_front();
      checks++;
      if (memVal !== e) begin
        errors++;
        $display("FAIL read addr=%h got=%h exp=%h t=%0t", memAddr, memVal, e, $time);
      end
    end
    if (endReq && !monDone) begin
      checks++;
      if (exp_sum_q.size() != 0) begin
        errors++;
        $display("FAIL missing_done got=%0d pending exp=0", exp_sum_q.size());
      end
      monDone = 1'b1;
    end
  end

  task automatic pushSt(input logic h, input logic r, input logic d);
    exp_st_q.push_back({h, r, d});
  endtask

  task automatic rd(input logic [7:0] a);
    @(posedge clk);
    #1;
    memAddr = a;
    exp_rd_q.push_back(modelRun ? refMem[a] : 8'h00);
  endtask

  // mode 0: full rate, 1: valid pattern 1,0,0 repeating, 2: random gaps.
  // The start cycle always carries a junk byte that must not be accepted.
  task automatic doLoad(input int len, input int mode);
    int         n;
    int         acc;
    int         cyc;
    logic [7:0] sum;
    logic [7:0] ptr;
    bit         v;
    n   = (len == 0) ? 256 : len;
    sum = 8'h00;
    for (int k = 0; k < n; k++) sum = sum + srcBuf[k];
    @(posedge clk);
    #1;
    loadStart = 1'b1;
    loadLen   = len[7:0];
    loadValid = 1'b1;
    loadData  = 8'hEE;
    @(posedge clk);
    #1;
    loadStart = 1'b0;
    loadValid = 1'b0;
    modelRun  = 1'b0;
    exp_sum_q.push_back(sum);
    pushSt(1'b1, 1'b1, 1'b0);
    acc = 0;
    cyc = 0;
    ptr = 8'h00;
    while (acc < n && cyc < 1500) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      loadValid = v;
      loadData  = srcBuf[acc];
      @(posedge clk);
      #1;
      if (v) begin
        refMem[ptr] = srcBuf[acc];
        refWr[ptr]  = 1'b1;
        ptr++;
        acc++;
      end
      cyc++;
      loadValid = 1'b0;
      if (acc == n) pushSt(1'b0, 1'b0, 1'b1);
      else          pushSt(1'b1, 1'b1, 1'b0);
    end
    if (acc == n) modelRun = 1'b1;
    else          pushSt(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst       = 1'b0;
    loadStart = 1'b0;
    loadLen   = 8'h00;
    loadValid = 1'b0;
    loadData  = 8'h00;
    memAddr   = 8'h00;
    modelRun  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    @(posedge clk);
    #1;
    pushSt(1'b1, 1'b0, 1'b0);
    exp_lsum_q.push_back(8'h00);
    rd(8'h05);

    // Full 256-byte load, length encoded as 0
    for (int i = 0; i < 256; i++) srcBuf[i] = i[7:0];
    doLoad(0, 0);
    rd(8'hFF);
    rd(8'h00);
    rd(8'h80);

    // Four bytes at full rate, then the same load with gapped valid
    srcBuf[0] = 8'h11; srcBuf[1] = 8'h22; srcBuf[2] = 8'h33; srcBuf[3] = 8'h44;
    doLoad(4, 0);
    for (int i = 0; i < 4; i++) rd(i[7:0]);
    rd(8'h04);
    doLoad(4, 1);
    for (int i = 0; i < 4; i++) rd(i[7:0]);

    // Reload from RUN with a shorter program
    srcBuf[0] = 8'h5A; srcBuf[1] = 8'hA5;
    doLoad(2, 0);
    for (int i = 0; i < 4; i++) rd(i[7:0]);

    // Reset in the middle of a load
    srcBuf[0] = 8'h01; srcBuf[1] = 8'h02;
    @(posedge clk);
    #1;
    loadStart = 1'b1;
    loadLen   = 8'd4;
    @(posedge clk);
    #1;
    loadStart = 1'b0;
    modelRun  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      loadValid = 1'b1;
      loadData  = srcBuf[i];
      @(posedge clk);
      #1;
      refMem[i] = srcBuf[i];
      refWr[i]  = 1'b1;
    end
    loadValid = 1'b0;
    rst = 1'b0;
    #1;
    memAddr = 8'h00;
    pushSt(1'b1, 1'b0, 1'b0);
    exp_lsum_q.push_back(8'h00);
    exp_rd_q.push_back(8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    srcBuf[0] = 8'hC3; srcBuf[1] = 8'h3C; srcBuf[2] = 8'h99; srcBuf[3] = 8'h66;
    doLoad(4, 0);
    for (int i = 0; i < 4; i++) rd(i[7:0]);

    // Randomized loads and reads of written addresses
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) srcBuf[k] = 8'($urandom_range(0, 255));
      doLoad(len, 2);
      for (int k = 0; k < 4; k++) rd(8'($urandom_range(0, len - 1)));
    end

    @(posedge clk);
    #1;
    endReq = 1'b1;
    for (int i = 0; i < 10 && !monDone; i++) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
